// File: rtl/video_pkg.sv
// Shared definitions for the 720p test-pattern generator: raster timing, box geometry,
// pattern encodings and colour constants.
package video_pkg;

  localparam int unsigned H_ACTIVE = 1280;
  localparam int unsigned V_ACTIVE = 720;
  localparam int unsigned H_TOTAL  = 1650;
  localparam int unsigned V_TOTAL  = 750;
  localparam int unsigned BOX_SIZE = 64;
  localparam int unsigned BOX_STEP = 2;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } vpg_mode_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_BOX_BG  = 24'h000040;

  // Colour-bar palette, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    unique case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vpg_box_motion.sv
// Bouncing-box position tracker. Advances once per frame boundary, clamping at the active-area
// edges and reversing direction there. Only compiled when VPG_BOX_EN is defined.
`ifdef VPG_BOX_EN
module vpg_box_motion
  import video_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fb_i,
  output logic [10:0] bx_o,
  output logic [10:0] by_o
);

  localparam logic [10:0] XLim = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YLim = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Step = 11'(BOX_STEP);

  logic [10:0] bx_q, bx_d, by_q, by_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving towards larger coordinate

  // Returns {new_dir, new_pos}; landing exactly on a limit counts as a bounce.
  function automatic logic [11:0] advance(input logic [10:0] pos, input logic dir,
                                          input logic [10:0] lim);
    logic [11:0] res;
    if (dir) begin
      if (pos >= lim - Step) res = {1'b0, lim};
      else                   res = {1'b1, pos + Step};
    end else begin
      if (pos <= Step) res = {1'b1, 11'd0};
      else             res = {1'b0, pos - Step};
    end
    return res;
  endfunction

  // Next position/direction: move only on the frame boundary.
  always_comb begin
    bx_d    = bx_q;
    by_d    = by_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (fb_i) begin
      {dir_x_d, bx_d} = advance(bx_q, dir_x_q, XLim);
      {dir_y_d, by_d} = advance(by_q, dir_y_q, YLim);
    end
  end

  // Position and direction registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bx_q    <= '0;
      by_q    <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      bx_q    <= bx_d;
      by_q    <= by_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign bx_o = bx_q;
  assign by_o = by_q;

endmodule
`endif

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source for the 720p60 HDMI transmitter. RGB is registered one pixclk after
// the raster position; pattern changes are held pending and applied on the frame boundary.
// Build option: define VPG_BOX_EN to make mode 3 a bouncing box (otherwise mode 3 is black).
module video_pattern_gen
  import video_pkg::*;
(
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic [10:0] CounterX,
  input  logic [10:0] CounterY,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [1:0]  mode_active,
  output logic        mode_busy,
  output logic        frame_start
);

  logic        fb;
  logic        active;
  logic [2:0]  bar_idx;
  logic [23:0] pix_rgb;

  vpg_mode_e   mode_active_q, mode_active_d;
  vpg_mode_e   pending_q, pending_d;
  logic        busy_q, busy_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_start_q;
  logic [23:0] rgb_q;

  assign fb     = (CounterX == 11'(H_TOTAL - 1)) && (CounterY == 11'(V_TOTAL - 1));
  assign active = (CounterX < 11'(H_ACTIVE)) && (CounterY < 11'(V_ACTIVE));

`ifdef VPG_BOX_EN
  logic [10:0] bx, by;
  logic        in_box;

  vpg_box_motion u_box (
    .clk_i  (pixclk),
    .rst_ni (rst_n),
    .fb_i   (fb),
    .bx_o   (bx),
    .by_o   (by)
  );

  // Widened compares so bx + BOX_SIZE cannot wrap.
  assign in_box = (CounterX >= bx) && ({1'b0, CounterX} < ({1'b0, bx} + 12'(BOX_SIZE))) &&
                  (CounterY >= by) && ({1'b0, CounterY} < ({1'b0, by} + 12'(BOX_SIZE)));
`endif

  // Bar index: count how many bar thresholds X has reached.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (CounterX >= 11'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Pattern mux; blanking forces black.
  always_comb begin
    pix_rgb = COL_BLACK;
    if (active) begin
      unique case (mode_active_q)
        MODE_BARS:  pix_rgb = bar_colour(bar_idx);
        MODE_RAMP:  pix_rgb = {CounterX[7:0], CounterY[7:0], frame_cnt_q};
        MODE_CHECK: pix_rgb = (CounterX[5] ^ CounterY[5] ^ frame_cnt_q[6]) ? COL_WHITE
                                                                           : COL_BLACK;
`ifdef VPG_BOX_EN
        MODE_BOX:   pix_rgb = in_box ? COL_WHITE : COL_BOX_BG;
`else
        MODE_BOX:   pix_rgb = COL_BLACK;
`endif
        default:    pix_rgb = COL_BLACK;
      endcase
    end
  end

  // Request bookkeeping and frame counter. On a boundary the old pending mode is applied first,
  // so a request landing in that same cycle waits for the following boundary.
  always_comb begin
    mode_active_d = mode_active_q;
    pending_d     = pending_q;
    busy_d        = busy_q;
    frame_cnt_d   = frame_cnt_q;
    if (fb) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (busy_q) mode_active_d = pending_q;
      busy_d = 1'b0;
    end
    if (mode_req) begin
      pending_d = vpg_mode_e'(mode_sel);
      busy_d    = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_active_q <= MODE_BARS;
      pending_q     <= MODE_BARS;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      mode_active_q <= mode_active_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= fb;
      rgb_q         <= pix_rgb;
    end
  end

  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign mode_active = mode_active_q;
  assign mode_busy   = busy_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a driver pushes expected responses from a
// behavioural model, a monitor pops one per clock and compares.
module tb_video_pattern_gen;

  logic        pixclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [10:0] CounterX = '0;
  logic [10:0] CounterY = '0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = '0;
  logic [7:0]  red, green, blue;
  logic [1:0]  mode_active;
  logic        mode_busy, frame_start;

  video_pattern_gen dut (
    .pixclk      (pixclk),
    .rst_n       (rst_n),
    .CounterX    (CounterX),
    .CounterY    (CounterY),
    .mode_req    (mode_req),
    .mode_sel    (mode_sel),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .mode_active (mode_active),
    .mode_busy   (mode_busy),
    .frame_start (frame_start)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  mode;
    logic        busy;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state
  int m_mode, m_pend, m_busy, m_fc, m_bx, m_by, m_dx, m_dy;
  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_busy = 0; m_fc = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  function automatic logic [23:0] model_rgb(int x, int y);
    logic [23:0] c;
    if (x >= 1280 || y >= 720) return 24'h0;
    case (m_mode)
      0: c = bars[x / 160];
      1: c = {8'(x % 256), 8'(y % 256), 8'(m_fc)};
      2: c = ((((x / 32) % 2) ^ ((y / 32) % 2) ^ ((m_fc / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
      default: begin
`ifdef VPG_BOX_EN
        c = (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ? 24'hFFFFFF : 24'h000040;
`else
        c = 24'h0;
`endif
      end
    endcase
    return c;
  endfunction

  function automatic int bounce(int pos, inout int dir, input int lim);
    int n = pos + dir * 2;
    if (n <= 0) begin dir = 1; return 0; end
    if (n >= lim) begin dir = -1; return lim; end
    return n;
  endfunction

  // Drive one raster position and push the expected post-edge outputs.
  task automatic step(input int x, input int y, input bit req, input int sel);
    exp_t e;
    bit   fb;
    @(negedge pixclk);
    CounterX = 11'(x); CounterY = 11'(y); mode_req = req; mode_sel = 2'(sel);
    fb = (x == 1649 && y == 749);
    e.rgb = model_rgb(x, y);
    if (fb) begin
      m_fc = (m_fc + 1) % 256;
      if (m_busy != 0) m_mode = m_pend;
      m_busy = 0;
      m_bx = bounce(m_bx, m_dx, 1280 - 64);
      m_by = bounce(m_by, m_dy, 720 - 64);
    end
    if (req) begin m_pend = sel; m_busy = 1; end
    e.mode = 2'(m_mode);
    e.busy = (m_busy != 0);
    e.fs   = fb;
    exp_q.push_back(e);
  endtask

  task automatic fb_step(input bit req, input int sel);
    step(1649, 749, req, sel);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge pixclk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", {red, green, blue}, 24'h0);
    check("rst_mode", 24'(mode_active), 24'h0);
    check("rst_busy", 24'(mode_busy), 24'h0);
    check("rst_fs", 24'(frame_start), 24'h0);
    mode_req = 1'b0;
    repeat (2) @(posedge pixclk);
    model_reset();
    @(negedge pixclk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per clock while the driver is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge pixclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rgb", {red, green, blue}, e.rgb);
        check("mode_active", 24'(mode_active), 24'(e.mode));
        check("mode_busy", 24'(mode_busy), 24'(e.busy));
        check("frame_start", 24'(frame_start), 24'(e.fs));
      end
    end
  end

  initial begin
    model_reset();
    #3;
    check("init_rgb", {red, green, blue}, 24'h0);
    check("init_mode", 24'(mode_active), 24'h0);
    #20 rst_n = 1'b1;

    // Build up some state, then reset mid-frame.
    step(100, 100, 1, 2);
    fb_step(0, 0);
    step(300, 200, 1, 1);
    step(400, 250, 0, 0);
    do_reset();
    step(0, 0, 0, 0);

    // Colour bars and blanking
    step(160, 10, 0, 0);
    step(1279, 10, 0, 0);
    step(1300, 10, 0, 0);
    step(640, 719, 0, 0);
    step(640, 720, 0, 0);

    // Request mid-frame, applied at boundary
    step(500, 300, 1, 2);
    step(600, 400, 0, 0);
    step(1649, 748, 0, 0);
    fb_step(0, 0);
    step(0, 0, 0, 0);
    step(32, 0, 0, 0);

    // Last request wins; a request on the boundary waits a frame
    step(10, 100, 1, 1);
    step(20, 200, 1, 2);
    fb_step(0, 0);
    step(5, 5, 0, 0);
    fb_step(1, 3);
    step(5, 5, 0, 0);
    fb_step(0, 0);
    step(5, 5, 0, 0);

    // Ramp with frame_cnt = 5, then across the 255->0 wrap
    do_reset();
    step(0, 0, 1, 1);
    while (m_fc != 5) fb_step(0, 0);
    step(12'h1AB, 12'h0C3, 0, 0);
    repeat (250) fb_step(0, 0);
    step(12'h1AB, 12'h0C3, 0, 0);
    fb_step(0, 0);
    step(12'h1AB, 12'h0C3, 0, 0);

    // Randomized raster positions, boundaries and requests
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(15) == 0);
      if ($urandom_range(5) == 0) fb_step(r, int'($urandom_range(3)));
      else step(int'($urandom_range(1649)), int'($urandom_range(749)), r,
                int'($urandom_range(3)));
    end

`ifdef VPG_BOX_EN
    // Bouncing box: probe around the box corner every frame through both bounces.
    do_reset();
    step(0, 0, 1, 3);
    for (int f = 0; f < 700; f++) begin
      fb_step(0, 0);
      step(m_bx, m_by, 0, 0);
      step(m_bx + 64, m_by, 0, 0);
      step(m_bx + 63, m_by + 63, 0, 0);
      if (m_bx > 0) step(m_bx - 1, m_by, 0, 0);
    end
`endif

    repeat (2) @(posedge pixclk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
